vram_console: RTL



---
 rtl/vram_console_pkg.sv | 29 ++
 rtl/vram_addr_calc.sv | 26 ++
 rtl/vram_console.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/vram_console_pkg.sv
// vram_console_pkg: shared screen geometry, control codes and state encoding
// for the text-VRAM character writer.
`default_nettype none

package vram_console_pkg;

  localparam int COLS_DEF = 40;
  localparam int ROWS_DEF = 30;
  localparam int AW_DEF   = 11;

  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_FF = 8'h0C;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLR_ROW = 2'd1,
    CLR_ALL = 2'd2
  } state_e;

  // Everything from 0x20 upward except DEL lands on screen as a glyph.
  function automatic logic is_printable(input logic [7:0] b);
    return (b >= 8'h20) && (b != 8'h7F);
  endfunction

endpackage

`default_nettype wire

// File: rtl/vram_addr_calc.sv
// vram_addr_calc: combinational cell address row*COLS+col; shift-add for the
// 40-column screen, generic multiply otherwise.
`default_nettype none

module vram_addr_calc
  import vram_console_pkg::*;
#(
  parameter int COLS = COLS_DEF,
  parameter int AW   = AW_DEF
) (
  input  logic [4:0]    row_i,
  input  logic [5:0]    col_i,
  output logic [AW-1:0] addr_o
);

  generate
    if (COLS == 40) begin : g_shift_add
      assign addr_o = (AW'(row_i) << 5) + (AW'(row_i) << 3) + AW'(col_i);
    end else begin : g_multiply
      assign addr_o = AW'(row_i) * AW'(COLS) + AW'(col_i);
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/vram_console.sv
// vram_console: byte-stream console writer for the 40x30 text VRAM; tracks a
// cursor, handles LF/CR/BS/FF, and scrolls by wrapping with a row clear.
`default_nettype none

module vram_console
  import vram_console_pkg::*;
#(
  parameter int         COLS = COLS_DEF,
  parameter int         ROWS = ROWS_DEF,
  parameter int         AW   = AW_DEF,
  parameter logic [7:0] FILL = 8'h20
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic [AW-1:0] vram_waddr,
  output logic [7:0]    vram_wdata,
  output logic          vram_we,
  output logic [5:0]    cur_col,
  output logic [4:0]    cur_row,
  output logic          busy
);

  localparam logic [AW-1:0] LAST_CELL    = AW'(COLS * ROWS - 1);
  localparam logic [AW-1:0] LAST_COL_CNT = AW'(COLS - 1);
  localparam logic [5:0]    LAST_COL     = 6'(COLS - 1);
  localparam logic [4:0]    LAST_ROW     = 5'(ROWS - 1);

  state_e        state_q, state_d;
  logic [5:0]    col_q, col_d;
  logic [4:0]    row_q, row_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;

  logic [4:0]    row_adv;
  logic [5:0]    calc_col;
  logic [AW-1:0] calc_addr;
  logic          accept;

  // One address calculator serves both the cursor write and the row clear.
  assign calc_col = (state_q == CLR_ROW) ? cnt_q[5:0] : col_q;
  assign row_adv  = (row_q == LAST_ROW) ? 5'd0 : row_q + 5'd1;
  assign accept   = in_valid && ready_q;

  vram_addr_calc #(
    .COLS (COLS),
    .AW   (AW)
  ) u_addr_calc (
    .row_i  (row_q),
    .col_i  (calc_col),
    .addr_o (calc_addr)
  );

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_printable(in_data)) begin
            we_d    = 1'b1;
            waddr_d = calc_addr;
            wdata_d = in_data;
            if (col_q == LAST_COL) begin
              col_d   = 6'd0;
              row_d   = row_adv;
              cnt_d   = '0;
              state_d = CLR_ROW;
            end else begin
              col_d = col_q + 6'd1;
            end
          end else if (in_data == CH_LF) begin
            col_d   = 6'd0;
            row_d   = row_adv;
            cnt_d   = '0;
            state_d = CLR_ROW;
          end else if (in_data == CH_CR) begin
            col_d = 6'd0;
          end else if (in_data == CH_BS) begin
            if (col_q != 6'd0) begin
              col_d   = col_q - 6'd1;
              we_d    = 1'b1;
              waddr_d = calc_addr - AW'(1);
              wdata_d = FILL;
            end
          end else if (in_data == CH_FF) begin
            col_d   = 6'd0;
            row_d   = 5'd0;
            cnt_d   = '0;
            state_d = CLR_ALL;
          end
        end
      end
      CLR_ROW: begin
        we_d    = 1'b1;
        waddr_d = calc_addr;
        wdata_d = FILL;
        if (cnt_q == LAST_COL_CNT) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      CLR_ALL: begin
        we_d    = 1'b1;
        waddr_d = cnt_q;
        wdata_d = FILL;
        if (cnt_q == LAST_CELL) begin
          col_d   = 6'd0;
          row_d   = 5'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      default: begin
        state_d = CLR_ALL;
        cnt_d   = '0;
      end
    endcase

    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLR_ALL;
      col_q   <= 6'd0;
      row_q   <= 5'd0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= 8'd0;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign in_ready   = ready_q;
  assign busy       = busy_q;
  assign vram_we    = we_q;
  assign vram_waddr = waddr_q;
  assign vram_wdata = wdata_q;
  assign cur_col    = col_q;
  assign cur_row    = row_q;

endmodule

`default_nettype wire
